// File: rtl/pipe_hazard_ctl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Generates PC / IF/ID / ID/EX / EX/MEM latch controls for load-use stalls,
// taken-branch flushes (branch resolved in MEM) and data-memory wait freezes,
// with a sticky memory-timeout fault and saturating stall/flush statistics.
module pipe_hazard_ctl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             pipe_freeze,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFault   = 2'd2,
    StBad     = 2'd3
  } state_e;

  localparam logic [7:0]       TimeoutVal = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [7:0]       wait_inc;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic load_use;
  logic mem_stall;
  logic flush_evt;
  logic stall_evt;

  // Load in EX whose destination is read by the instruction in ID ($0 never hazards).
  assign load_use = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mem_stall = mem_access && !dmem_ready;
  assign wait_inc  = wait_q + 8'd1;

  // State, wait counter, fault flag and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      wait_q  <= 8'd0;
      fault_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic: enter wait on an unfinished access, time out into FAULT.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d = StMemWait;
          wait_d  = 8'd1;
        end
      end
      StMemWait: begin
        if (dmem_ready) begin
          state_d = StRun;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TimeoutVal) begin
            state_d = StFault;
            fault_d = 1'b1;
          end
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StFault;
        fault_d = 1'b1;
      end
    endcase
  end

  // Latch controls: zero-latency decode of state and hazard inputs.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    pipe_freeze = 1'b0;
    if (rst) begin
      // Pipeline is emptied while held in reset.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state_q)
        StRun: begin
          if (mem_stall) begin
            pipe_freeze = 1'b1;
          end else if (mem_branch_taken) begin
            // Redirect wins over a load-use stall: the younger instructions die anyway.
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
          end else if (load_use) begin
            idex_bubble = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        StMemWait: begin
          pipe_freeze = !dmem_ready;
          pc_write    = dmem_ready;
          ifid_write  = dmem_ready;
        end
        default: begin
          pipe_freeze = 1'b1;
        end
      endcase
    end
  end

  assign flush_evt = (state_q == StRun) && !mem_stall && mem_branch_taken;
  assign stall_evt = !pc_write && ((state_q == StRun) || (state_q == StMemWait));

  // Saturating statistics counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_evt && (stall_q != CntMax)) begin
      stall_d = stall_q + CntOne;
    end
    if (flush_evt && (flush_q != CntMax)) begin
      flush_d = flush_q + CntOne;
    end
  end

  assign fault     = fault_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: a default-parameter instance and a small one
// (MEM_TIMEOUT=4, CNT_W=4) share the same stimulus and are compared against
// a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, mem_branch_taken, mem_access, dmem_ready;

  logic [1:0]  pc_w, ifid_w, ifid_f, idex_b, exmem_f, frz, flt;
  logic [1:0]  st0, st1;
  logic [15:0] stall0, flush0;
  logic [3:0]  stall1, flush1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctl u_dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .pc_write(pc_w[0]),
    .ifid_write(ifid_w[0]), .ifid_flush(ifid_f[0]), .idex_bubble(idex_b[0]),
    .exmem_flush(exmem_f[0]), .pipe_freeze(frz[0]), .fault(flt[0]),
    .stall_cnt(stall0), .flush_cnt(flush0), .state(st0)
  );

  pipe_hazard_ctl #(.MEM_TIMEOUT(4), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .pc_write(pc_w[1]),
    .ifid_write(ifid_w[1]), .ifid_flush(ifid_f[1]), .idex_bubble(idex_b[1]),
    .exmem_flush(exmem_f[1]), .pipe_freeze(frz[1]), .fault(flt[1]),
    .stall_cnt(stall1), .flush_cnt(flush1), .state(st1)
  );

  // Model state per instance: mode 0=run, 1=waiting on memory, 2=faulted.
  int m_mode[2], m_wait[2], m_stall[2], m_flush[2], m_fault[2];
  int tmo[2]  = '{16, 4};
  int cmax[2] = '{65535, 15};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected controls packed as {pc_write, ifid_write, ifid_flush, idex_bubble,
  // exmem_flush, pipe_freeze}.
  function automatic logic [5:0] exp_ctl(input int mode);
    logic src_hit, hazard;
    src_hit = (ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt));
    hazard  = ex_memread && (ex_rt != 5'd0) && src_hit;
    if (rst) return 6'b001110;
    if (mode == 0) begin
      if (mem_access && !dmem_ready) return 6'b000001;
      if (mem_branch_taken)          return 6'b111110;
      if (hazard)                    return 6'b000100;
      return 6'b110000;
    end
    if (mode == 1) return dmem_ready ? 6'b110000 : 6'b000001;
    return 6'b000001;
  endfunction

  function automatic logic [5:0] act_ctl(input int k);
    return {pc_w[k], ifid_w[k], ifid_f[k], idex_b[k], exmem_f[k], frz[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_wait[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_fault[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [5:0] c;
    if (rst) return;
    for (int k = 0; k < 2; k++) begin
      c = exp_ctl(m_mode[k]);
      if (m_mode[k] <= 1 && !c[5] && m_stall[k] < cmax[k]) m_stall[k]++;
      if (m_mode[k] == 0 && c[3] && m_flush[k] < cmax[k]) m_flush[k]++;
      case (m_mode[k])
        0: if (mem_access && !dmem_ready) begin m_mode[k] = 1; m_wait[k] = 1; end
        1: begin
          if (dmem_ready) m_mode[k] = 0;
          else begin
            m_wait[k]++;
            if (m_wait[k] == tmo[k]) begin m_mode[k] = 2; m_fault[k] = 1; end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d controls", k), 32'(act_ctl(k)), 32'(exp_ctl(m_mode[k])));
      check($sformatf("u%0d state", k), 32'(k == 0 ? st0 : st1), 32'(m_mode[k]));
      check($sformatf("u%0d fault", k), 32'(flt[k]), 32'(m_fault[k]));
      check($sformatf("u%0d stall_cnt", k), k == 0 ? 32'(stall0) : 32'(stall1), 32'(m_stall[k]));
      check($sformatf("u%0d flush_cnt", k), k == 0 ? 32'(flush0) : 32'(flush1), 32'(m_flush[k]));
    end
  endtask

  // Inputs are set just after a rising edge; outputs checked on the falling edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0;
    mem_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
  endtask

  // Reset is raised between edges so its asynchronous effect is visible at once.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("async reset fault u1", 32'(flt[1]), 32'd0);
    check("async reset state u1", 32'(st1), 32'd0);
    check_all();
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, memread;
    logic [4:0] xrt;
    logic       br, macc, rdy;
    logic [5:0] ctl;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int exp_stalls, exp_flushes;
    logic starve;
    rst = 1'b1;
    clear_inputs();
    model_reset();

    vecs[0] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 6'b110000};
    vecs[1] = '{5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 6'b000100};
    vecs[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 6'b110000};
    vecs[3] = '{5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 6'b110000};
    vecs[4] = '{5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 6'b000100};
    vecs[5] = '{5'd8, 5'd2, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 6'b111110};
    vecs[6] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 6'b111110};
    vecs[7] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1, 6'b110000};
    vecs[8] = '{5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b1, 6'b000100};
    vecs[9] = '{5'd4, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 6'b110000};

    do_reset();

    // Single-cycle RUN decode vectors.
    exp_stalls = 0;
    exp_flushes = 0;
    for (int i = 0; i < 10; i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
      ex_memread = vecs[i].memread; ex_rt = vecs[i].xrt; mem_branch_taken = vecs[i].br;
      mem_access = vecs[i].macc; dmem_ready = vecs[i].rdy;
      if (!vecs[i].ctl[5]) exp_stalls++;
      if (vecs[i].ctl[3]) exp_flushes++;
      @(negedge clk);
      check($sformatf("vec%0d controls", i), 32'(act_ctl(0)), 32'(vecs[i].ctl));
      check_all();
      @(posedge clk);
      model_step();
      #1;
    end
    clear_inputs();
    @(negedge clk);
    check("table stall_cnt", 32'(stall0), 32'(exp_stalls));
    check("table flush_cnt", 32'(flush0), 32'(exp_flushes));
    @(posedge clk);
    model_step();
    #1;

    // Memory wait: three frozen cycles, then the access completes.
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("wait%0d freeze", i), 32'(frz[0]), 32'd1);
      check($sformatf("wait%0d state", i), 32'(st0), i == 0 ? 32'd0 : 32'd1);
      check_all();
      @(posedge clk);
      model_step();
      #1;
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check("wait done freeze", 32'(frz[0]), 32'd0);
    check("wait done pc_write", 32'(pc_w[0]), 32'd1);
    @(posedge clk);
    model_step();
    #1;
    mem_access = 1'b0;
    @(negedge clk);
    check("wait back to run", 32'(st0), 32'd0);
    check("wait stall_cnt", 32'(stall0), 32'd3);
    @(posedge clk);
    model_step();
    #1;

    // Timeout: small instance faults after 4 stalled cycles and stays frozen.
    do_reset();
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    check("timeout fault", 32'(flt[1]), 32'd1);
    check("timeout state", 32'(st1), 32'd2);
    check("timeout freeze", 32'(frz[1]), 32'd1);
    check("timeout stall_cnt", 32'(stall1), 32'd4);
    check("no timeout at 16", 32'(st0), 32'd1);
    @(posedge clk);
    model_step();
    #1;
    dmem_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("fault held", 32'(st1), 32'd2);
    check("fault freeze held", 32'(frz[1]), 32'd1);
    check("fault no stall count", 32'(stall1), 32'd4);
    @(posedge clk);
    model_step();
    #1;
    do_reset();

    // Saturation: continuous load-use stall for 20 cycles.
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    check("sat stall_cnt small", 32'(stall1), 32'd15);
    check("sat stall_cnt big", 32'(stall0), 32'd20);
    @(posedge clk);
    model_step();
    #1;

    // Randomized traffic against the model.
    do_reset();
    starve = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      if (!starve && $urandom_range(0, 99) == 0) starve = 1'b1;
      else if (starve && $urandom_range(0, 24) == 0) starve = 1'b0;
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_memread = 1'($urandom_range(0, 1));
      ex_rt = 5'($urandom_range(0, 3));
      mem_branch_taken = ($urandom_range(0, 5) == 0);
      mem_access = ($urandom_range(0, 2) == 0);
      dmem_ready = starve ? 1'b0 : ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
